dmem_bridge: RTL and testbench

Data-memory bridge sitting directly downstream of the single-cycle datapath: it consumes the datapath's `aluout` (address) and `writedata` plus the controller's memory strobes, and returns `readdata`. It converts each single-cycle load/store into a req/ack transaction on a variable-latency backing memory. While the transaction is in flight it raises `stall` so the controller can freeze PC and register-file writes. It also flags misaligned accesses and memory timeouts.

---
 rtl/dmem_bridge.sv | 86 ++++++++
 tb/tb_dmem_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle load/store strobes into req/ack transactions on a variable-latency memory
module dmem_bridge #(
    parameter int n       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memread,
    input  logic         memwrite,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic         stall,
    output logic [1:0]   fault,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [n-1:0]  rdata_q;
    logic          access;
    logic          aligned;

    assign access  = memread | memwrite;
    assign aligned = addr[1:0] == 2'b00;
    assign cnt_nx  = cnt + CW'(1);

    // Freeze the datapath from the cycle an aligned access appears until the memory answers
    assign stall    = (state == IDLE && access && aligned) || state == BUSY;
    // A misaligned access completes immediately with zero data
    assign readdata = (state == IDLE && access && !aligned) ? '0 : rdata_q;

    // Transaction FSM with registered memory-side outputs and sticky fault flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_q   <= '0;
            fault     <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        state     <= BUSY;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= memwrite;
                        mem_addr  <= {addr[n-1:2], 2'b00};
                        mem_wdata <= writedata;
                    end else if (access) begin
                        fault[0] <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt_nx;
                    if (mem_ack) begin
                        if (!mem_we)
                            rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt_nx == CW'(TIMEOUT)) begin
                        rdata_q  <= '0;
                        fault[1] <= 1'b1;
                        mem_req  <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed self-checking bench for dmem_bridge
module tb_dmem_bridge;
    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int stalls;
    int bad;

    dmem_bridge #(.n(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .writedata(writedata), .readdata(readdata), .stall(stall),
        .fault(fault), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence ever wedges
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from its IDLE cycle; returns in the DONE cycle with strobes dropped.
    // ack_at counts cycles from the IDLE cycle (1 = first BUSY cycle), -1 = never ack.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rdv, output int st, output int bd);
        st = 0;
        bd = 0;
        memread = rd;
        memwrite = wr;
        addr = a;
        writedata = wd;
        for (int c = 0; c <= 40; c++) begin
            mem_ack = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdv : 32'h0;
            #1;
            if (!stall) break;
            st++;
            if (c == 0 && mem_req !== 1'b0) bd++;
            if (c >= 1 && (mem_req !== 1'b1 || mem_we !== wr || mem_addr !== a || (wr && mem_wdata !== wd))) bd++;
            if (c == 1) begin
                addr = a ^ 32'hFFFF_FF00;
                writedata = ~wd;
            end
            tick();
        end
        mem_ack = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        addr = '0;
        writedata = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        #2;
        check("rst_readdata", readdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Aligned load, ack in first BUSY cycle
        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hCAFE_F00D, stalls, bad);
        check("ld1_stall_cycles", stalls, 2);
        check("ld1_busy_outputs", bad, 0);
        check("ld1_done_readdata", readdata, 32'hCAFE_F00D);
        check("ld1_done_mem_req", 32'(mem_req), 32'h0);
        tick();
        check("ld1_idle_readdata", readdata, 32'hCAFE_F00D);

        // Misaligned load
        memread = 1'b1;
        addr = 32'h0000_0013;
        #1;
        check("mis_stall", 32'(stall), 32'h0);
        check("mis_readdata", readdata, 32'h0);
        check("mis_mem_req", 32'(mem_req), 32'h0);
        check("mis_fault_before", 32'(fault), 32'h0);
        tick();
        memread = 1'b0;
        #1;
        check("mis_fault_after", 32'(fault), 32'h1);
        check("mis_no_req", 32'(mem_req), 32'h0);
        check("mis_idle_readdata", readdata, 32'hCAFE_F00D);

        // Aligned load after misalignment, ack in second BUSY cycle
        txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 2, 32'h0BAD_BEEF, stalls, bad);
        check("ld2_stall_cycles", stalls, 3);
        check("ld2_busy_outputs", bad, 0);
        check("ld2_done_readdata", readdata, 32'h0BAD_BEEF);
        tick();

        // Aligned store, ack after 4 BUSY cycles; rdata on ack must not be captured
        txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4, 32'hDEAD_DEAD, stalls, bad);
        check("st_stall_cycles", stalls, 5);
        check("st_busy_outputs", bad, 0);
        check("st_readdata_kept", readdata, 32'h0BAD_BEEF);
        check("st_done_mem_req", 32'(mem_req), 32'h0);
        tick();

        // Both strobes: treated as a write
        txn(1'b1, 1'b1, 32'h0000_0040, 32'hAAAA_5555, 1, 32'h1111_1111, stalls, bad);
        check("both_stall_cycles", stalls, 2);
        check("both_busy_we", bad, 0);
        check("both_readdata_kept", readdata, 32'h0BAD_BEEF);
        tick();

        // Ack on the final allowed BUSY cycle wins over timeout
        txn(1'b1, 1'b0, 32'h0000_0060, 32'h0, 16, 32'h55AA_55AA, stalls, bad);
        check("ack16_stall_cycles", stalls, 17);
        check("ack16_busy_outputs", bad, 0);
        check("ack16_readdata", readdata, 32'h55AA_55AA);
        check("ack16_fault", 32'(fault), 32'h1);
        tick();

        // No ack at all: timeout
        txn(1'b1, 1'b0, 32'h0000_0070, 32'h0, -1, 32'h0, stalls, bad);
        check("to_stall_cycles", stalls, 17);
        check("to_busy_outputs", bad, 0);
        check("to_readdata", readdata, 32'h0);
        check("to_fault_done", 32'(fault), 32'h3);
        check("to_mem_req", 32'(mem_req), 32'h0);
        tick();
        check("to_fault_sticky", 32'(fault), 32'h3);

        // Reset asserted during BUSY of a load
        memread = 1'b1;
        addr = 32'h0000_0050;
        tick();
        check("rstmid_busy_req", 32'(mem_req), 32'h1);
        #2;
        reset = 1'b0;
        memread = 1'b0;
        #1;
        check("rstmid_mem_req", 32'(mem_req), 32'h0);
        check("rstmid_stall", 32'(stall), 32'h0);
        check("rstmid_fault", 32'(fault), 32'h0);
        check("rstmid_readdata", readdata, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_mem_req", 32'(mem_req), 32'h0);
            check("post_rst_stall", 32'(stall), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
